tx_pwr_ctrl: RTL
================

Name: tx_pwr_ctrl

Overview:
Power-sequencing controller for the tx power domain. It watches the tx block's idle output and the requester-side wake request, then steps the domain through the following sequence:
- clock gate
- isolation
- state save
- power-switch off
- power-switch on, restore, de-isolation and clock ungate

It sits between the tx block and the always-on power switch / retention cells. It tells requesters when tx is usable via pwr_up.

Parameters:
IDLE_HOLD, 4, consecutive cycles idle must be high before power-down starts (1..15).
ISO_DLY, 2, cycles spent in each isolation-settle state (1..7).
PWR_SETTLE, 4, cycles waited after pwr_ack rises before restore (1..15).
ACK_TO, 32, max cycles waiting for pwr_ack to change before error (2..255).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
idle  input  1  tx idle indication
wake_req  input  1  requester wants tx (tx_vld, always-on side)
pwr_ack  input  1  power switch status, 1 = domain powered
pwr_up  output  1  domain fully on and usable
clk_en  output  1  tx clock-gate enable
iso_en  output  1  isolation enable, tx outputs clamped
save  output  1  one-cycle retention save pulse
restore  output  1  one-cycle retention restore pulse
pwr_sw_en  output  1  power switch enable
dom_rst  output  1  reset to tx domain
pwr_state  output  4  current FSM state encoding
err  output  1  sticky pwr_ack timeout flag

Behaviour:
- Reset values: pwr_state=ON, pwr_up=1, clk_en=1, iso_en=0, save=0, restore=0, pwr_sw_en=1, dom_rst=0, err=0, all counters 0.
- All outputs are registered and decoded from the state register; none is a combinational function of the inputs.
- idle_cnt: increments while idle && !wake_req in ON, saturating at IDLE_HOLD; cleared otherwise.

FSM states and transitions:
- ON: pwr_up=1. Go to CLK_OFF when idle_cnt==IDLE_HOLD and !wake_req.
- CLK_OFF (1 cycle): clk_en=0, pwr_up=0.
  - wake_req → CLK_ON (abort).
  - Else → ISO.
- ISO (ISO_DLY cycles): iso_en=1.
  - wake_req → DEISO (abort, no state lost).
  - Else at count end → SAVE.
- SAVE (1 cycle): save=1 → PWR_DN. From here power-down is committed; wake_req is ignored until OFF.
- PWR_DN: pwr_sw_en=0, wait pwr_ack==0.
  - Goes to OFF.
  - After ACK_TO cycles: err=1, go to OFF anyway.
- OFF: domain dark. Go to PWR_ON when wake_req=1.
- PWR_ON: pwr_sw_en=1, dom_rst=1.
  - Wait pwr_ack==1, then PWR_SETTLE more cycles → RESTORE.
  - ACK_TO timeout: err=1, remain in PWR_ON, keep retrying.
- RESTORE (1 cycle): dom_rst=0, restore=1 → DEISO.
- DEISO (ISO_DLY cycles): iso_en=0 → CLK_ON.
- CLK_ON (1 cycle): clk_en=1 → ON.

Timing and counters:
- Nominal wake latency, OFF to pwr_up=1, with pwr_ack arriving N cycles after pwr_sw_en: N + PWR_SETTLE + ISO_DLY + 3.
- Timer counters are 8-bit, load on state entry and never wrap.
- err clears only on reset.

Boundary conditions:
- wake_req and the idle threshold in the same cycle: wake wins, stay ON.
- pwr_ack dropping while in ON: err=1, state unchanged.
- Reset mid-sequence returns to ON with the switch enabled. The tx domain must be reset by the same signal.

Optional Feature:
- Macro: TX_PWR_RETENTION_EN.
- Defined: SAVE and RESTORE states exist and the save/restore pulses are generated as above.
- Undefined:
  - SAVE and RESTORE are skipped; ISO goes directly to PWR_DN, and PWR_ON goes to DEISO after settle.
  - save=restore=0 constantly.
  - dom_rst is held through DEISO and released on entry to CLK_ON, so tx restarts from its reset state. This means idle_time reverts to its reset value, and software must rewrite the register.

Decomposition:
- Package tx_pwr_pkg holds:
  - the 4-bit state encoding constants (ON=0, CLK_OFF, ISO, SAVE, PWR_DN, OFF, PWR_ON, RESTORE, DEISO, CLK_ON);
  - the default parameter values;
  - the counter width constant (8).
- One sub-module is natural: tx_pwr_timer, a loadable down-counter with a done flag. It is shared by the ISO_DLY, PWR_SETTLE and ACK_TO waits.

Test Plan:
- Power-down: defaults, idle=1 and wake_req=0 for 4 cycles → CLK_OFF, ISO 2 cycles, save pulse, pwr_sw_en=0. pwr_ack falls after 3 cycles → OFF, pwr_up=0.
- Wake: from OFF, wake_req=1, pwr_ack rises 5 cycles after pwr_sw_en → pwr_up=1 exactly 5+4+2+3=14 cycles later; restore is a single-cycle pulse.
- Abort during ISO: wake_req=1 in the first ISO cycle → no save pulse, pwr_sw_en stays 1, DEISO then CLK_ON, pwr_up=1 after 4 cycles.
- Timeout: pwr_ack held 1 in PWR_DN for 32 cycles → err=1, state OFF. A later wake with pwr_ack never rising → stays PWR_ON, err remains 1.
- Reset mid-sequence: assert reset in PWR_DN → immediately pwr_state=ON, pwr_sw_en=1, iso_en=0, clk_en=1, err=0.
- Macro off: repeat the power-down/wake case → no save/restore pulses, dom_rst high until CLK_ON entry, wake latency 13 cycles.

Source files
------------

// File: rtl/tx_pwr_pkg.sv
// rtl/tx_pwr_pkg.sv - tx power sequencer types, defaults and output decode; honours TX_PWR_RETENTION_EN
package tx_pwr_pkg;

   localparam int CNT_W          = 8;
   localparam int IDLE_HOLD_DEF  = 4;
   localparam int ISO_DLY_DEF    = 2;
   localparam int PWR_SETTLE_DEF = 4;
   localparam int ACK_TO_DEF     = 32;

   typedef enum logic [3:0] {
      ST_ON      = 4'd0,
      ST_CLK_OFF = 4'd1,
      ST_ISO     = 4'd2,
      ST_SAVE    = 4'd3,
      ST_PWR_DN  = 4'd4,
      ST_OFF     = 4'd5,
      ST_PWR_ON  = 4'd6,
      ST_RESTORE = 4'd7,
      ST_DEISO   = 4'd8,
      ST_CLK_ON  = 4'd9
   } pwr_state_e;

   typedef struct packed {
      logic pwr_up;
      logic clk_en;
      logic iso_en;
      logic save;
      logic restore;
      logic pwr_sw_en;
      logic dom_rst;
   } pwr_out_t;

   // Per-state control outputs; without retention, dom_rst stays high
   // through DEISO so tx comes back from its reset state.
   function automatic pwr_out_t decode_outputs(input pwr_state_e st);
      pwr_out_t o;
      o.pwr_up    = 1'b0;
      o.clk_en    = 1'b0;
      o.iso_en    = 1'b1;
      o.save      = 1'b0;
      o.restore   = 1'b0;
      o.pwr_sw_en = 1'b1;
      o.dom_rst   = 1'b0;
      case (st)
         ST_ON: begin
            o.pwr_up = 1'b1;
            o.clk_en = 1'b1;
            o.iso_en = 1'b0;
         end
         ST_CLK_OFF: o.iso_en = 1'b0;
`ifdef TX_PWR_RETENTION_EN
         ST_SAVE:    o.save = 1'b1;
         ST_RESTORE: o.restore = 1'b1;
`endif
         ST_PWR_DN:  o.pwr_sw_en = 1'b0;
         ST_OFF:     o.pwr_sw_en = 1'b0;
         ST_PWR_ON:  o.dom_rst = 1'b1;
         ST_DEISO: begin
            o.iso_en = 1'b0;
`ifndef TX_PWR_RETENTION_EN
            o.dom_rst = 1'b1;
`endif
         end
         ST_CLK_ON: begin
            o.clk_en = 1'b1;
            o.iso_en = 1'b0;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/tx_pwr_ctrl_if.sv
// rtl/tx_pwr_ctrl_if.sv - tx power sequencer status/control bundle
interface tx_pwr_ctrl_if;

   logic       idle;
   logic       wake_req;
   logic       pwr_ack;
   logic       pwr_up;
   logic       clk_en;
   logic       iso_en;
   logic       save;
   logic       restore;
   logic       pwr_sw_en;
   logic       dom_rst;
   logic [3:0] pwr_state;
   logic       err;

   modport master (
      output idle, wake_req, pwr_ack,
      input  pwr_up, clk_en, iso_en, save, restore, pwr_sw_en, dom_rst, pwr_state, err
   );

   modport slave (
      input  idle, wake_req, pwr_ack,
      output pwr_up, clk_en, iso_en, save, restore, pwr_sw_en, dom_rst, pwr_state, err
   );

endinterface

// File: rtl/tx_pwr_timer.sv
// rtl/tx_pwr_timer.sv - loadable saturating down-counter with zero flag
module tx_pwr_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q;

   // Load wins; otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/tx_pwr_ctrl.sv
// rtl/tx_pwr_ctrl.sv - tx power-domain sequencer; TX_PWR_RETENTION_EN adds SAVE/RESTORE
module tx_pwr_ctrl
   import tx_pwr_pkg::*;
#(
   parameter int IDLE_HOLD  = IDLE_HOLD_DEF,
   parameter int ISO_DLY    = ISO_DLY_DEF,
   parameter int PWR_SETTLE = PWR_SETTLE_DEF,
   parameter int ACK_TO     = ACK_TO_DEF
) (
   input logic          clk,
   input logic          reset,
   tx_pwr_ctrl_if.slave bus
);

   // Timer loads are one less than the dwell: done is seen on the last cycle.
   localparam logic [3:0]       IDLE_HOLD_C = 4'(IDLE_HOLD);
   localparam logic [CNT_W-1:0] ISO_LD      = CNT_W'(ISO_DLY - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(PWR_SETTLE - 1);
   localparam logic [CNT_W-1:0] ACK_LD      = CNT_W'(ACK_TO - 1);

   pwr_state_e       state_q, state_d;
   logic [3:0]       idle_cnt_q, idle_cnt_d;
   logic             acked_q, acked_d;
   logic             err_q, err_d;
   pwr_out_t         out_q, out_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   tx_pwr_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Next state, idle qualification, ack timeouts and per-state timer loads.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      acked_d    = acked_q;
      err_d      = err_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;

      case (state_q)
         ST_ON: begin
            if (bus.idle && !bus.wake_req) begin
               idle_cnt_d = (idle_cnt_q == IDLE_HOLD_C) ? idle_cnt_q : idle_cnt_q + 4'd1;
            end
            if (!bus.pwr_ack) begin
               err_d = 1'b1;
            end
            if ((idle_cnt_q == IDLE_HOLD_C) && !bus.wake_req) begin
               state_d = ST_CLK_OFF;
            end
         end
         ST_CLK_OFF: state_d = bus.wake_req ? ST_CLK_ON : ST_ISO;
         ST_ISO: begin
            if (bus.wake_req) begin
               state_d = ST_DEISO;
            end else if (tmr_done) begin
`ifdef TX_PWR_RETENTION_EN
               state_d = ST_SAVE;
`else
               state_d = ST_PWR_DN;
`endif
            end
         end
         ST_SAVE: state_d = ST_PWR_DN;
         ST_PWR_DN: begin
            if (!bus.pwr_ack) begin
               state_d = ST_OFF;
            end else if (tmr_done) begin
               err_d   = 1'b1;
               state_d = ST_OFF;
            end
         end
         ST_OFF: begin
            if (bus.wake_req) begin
               state_d = ST_PWR_ON;
            end
         end
         ST_PWR_ON: begin
            if (!acked_q) begin
               if (bus.pwr_ack) begin
                  acked_d  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = SETTLE_LD;
               end else if (tmr_done) begin
                  err_d    = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = ACK_LD;
               end
            end else if (tmr_done) begin
`ifdef TX_PWR_RETENTION_EN
               state_d = ST_RESTORE;
`else
               state_d = ST_DEISO;
`endif
            end
         end
         ST_RESTORE: state_d = ST_DEISO;
         ST_DEISO: begin
            if (tmr_done) begin
               state_d = ST_CLK_ON;
            end
         end
         ST_CLK_ON: state_d = ST_ON;
         default:   state_d = ST_ON;
      endcase

      if (state_d != state_q) begin
         acked_d = 1'b0;
         case (state_d)
            ST_ISO, ST_DEISO: begin
               tmr_load = 1'b1;
               tmr_val  = ISO_LD;
            end
            ST_PWR_DN, ST_PWR_ON: begin
               tmr_load = 1'b1;
               tmr_val  = ACK_LD;
            end
            default: ;
         endcase
      end

      out_d = decode_outputs(state_d);
   end

   // State, counters, sticky error and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ON;
         idle_cnt_q <= '0;
         acked_q    <= 1'b0;
         err_q      <= 1'b0;
         out_q      <= decode_outputs(ST_ON);
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         acked_q    <= acked_d;
         err_q      <= err_d;
         out_q      <= out_d;
      end
   end

   assign bus.pwr_up    = out_q.pwr_up;
   assign bus.clk_en    = out_q.clk_en;
   assign bus.iso_en    = out_q.iso_en;
   assign bus.save      = out_q.save;
   assign bus.restore   = out_q.restore;
   assign bus.pwr_sw_en = out_q.pwr_sw_en;
   assign bus.dom_rst   = out_q.dom_rst;
   assign bus.pwr_state = state_q;
   assign bus.err       = err_q;

endmodule
